// File: rtl/cpu_types_pkg.sv
// Types shared across the CPU: RAM status codes and the machine word.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bus between the two caches, the arbiter and the RAM port.
// The arbiter connects through the slave modport. Whatever drives the caches and the RAM uses the master modport.
interface memory_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;

    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      ramerr;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
    );

endinterface

// File: rtl/memory_arbiter.sv
// Arbitrates one RAM port between icache and dcache. The dcache has priority.
// The icache gets the port after STARVE_LIMIT back-to-back dcache completions.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic              CLK,
    input logic              nRST,
    memory_arbiter_if.slave  bus
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_starve_limit
        $error("memory_arbiter: STARVE_LIMIT must be in 1..7");
    end

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        DGRANT,
        IGRANT
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] dstreak_q, dstreak_d;
    logic       ramerr_q, ramerr_d;

    logic       d_req;
    logic       d_done;
    logic       i_done;

    // A completion needs the grantee to still be requesting. A request dropped in the ACCESS cycle aborts the transfer.
    always_comb begin
        d_req  = bus.dREN | bus.dWEN;
        d_done = (state_q == DGRANT) && d_req    && (bus.ramstate == ACCESS);
        i_done = (state_q == IGRANT) && bus.iREN && (bus.ramstate == ACCESS);
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (d_req && (!bus.iREN || dstreak_q < LIMIT)) begin
                    state_d = DGRANT;
                end else if (bus.iREN) begin
                    state_d = IGRANT;
                end
            end
            DGRANT:  if (!d_req || d_done)    state_d = IDLE;
            IGRANT:  if (!bus.iREN || i_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ramerr_d = ramerr_q | ((state_q != IDLE) && (bus.ramstate == ERROR));

        dstreak_d = dstreak_q;
        if (!bus.iREN || i_done) begin
            dstreak_d = 3'd0;
        end else if (d_done && dstreak_q < LIMIT) begin
            dstreak_d = dstreak_q + 3'd1;
        end
    end

    // Outputs decode straight from state_q. An asynchronous reset therefore drops the RAM strobes at once.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = bus.ramload;
        bus.dload    = bus.ramload;
        bus.ramerr   = ramerr_q;
        unique case (state_q)
            DGRANT: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.dwait    = ~d_done;
            end
            IGRANT: begin
                bus.ramaddr = bus.iaddr;
                bus.ramREN  = 1'b1;
                bus.iwait   = ~i_done;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, with an asynchronous active-low reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            dstreak_q <= 3'd0;
            ramerr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            dstreak_q <= dstreak_d;
            ramerr_q  <= ramerr_d;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Runs directed scenarios for the arbiter, then random cache traffic against a RAM model with variable latency.
// A queue-based scoreboard checks each completion of the random traffic.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int LIMIT = 4;

    logic clk;
    logic nrst;

    memory_arbiter_if bus ();

    memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // ---------------- RAM model ----------------
    bit        ram_auto = 1'b0;
    int        lat_min  = 1;
    int        lat_max  = 1;
    bit        err_en   = 1'b0;
    bit        exp_err  = 1'b0;
    ramstate_t man_state = FREE;
    word_t     man_load  = '0;
    word_t     ram_mem [word_t];

    initial begin
        bit ram_active;
        int ram_lat;
        bit ram_err;
        ram_active   = 1'b0;
        ram_lat      = 0;
        ram_err      = 1'b0;
        bus.ramstate = FREE;
        bus.ramload  = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!ram_auto) begin
                ram_active   = 1'b0;
                bus.ramstate = man_state;
                bus.ramload  = man_load;
            end else if (bus.ramREN || bus.ramWEN) begin
                if (!ram_active) begin
                    ram_active = 1'b1;
                    ram_lat    = $urandom_range(lat_max, lat_min);
                    ram_err    = err_en && ($urandom_range(0, 7) == 0);
                end
                bus.ramload = $urandom;
                if (ram_lat > 0) begin
                    bus.ramstate = BUSY;
                    ram_lat--;
                end else if (ram_err) begin
                    bus.ramstate = ERROR;
                    ram_err      = 1'b0;
                    exp_err      = 1'b1;
                end else begin
                    bus.ramstate = ACCESS;
                    ram_active   = 1'b0;
                    if (bus.ramWEN) ram_mem[bus.ramaddr] = bus.ramstore;
                    else bus.ramload = ram_mem.exists(bus.ramaddr) ? ram_mem[bus.ramaddr]
                                                                    : init_word(bus.ramaddr);
                end
            end else begin
                ram_active   = 1'b0;
                bus.ramstate = FREE;
                bus.ramload  = $urandom;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t  dq[$];
    txn_t  iq[$];
    word_t ref_mem [word_t];
    bit    sb_on = 1'b0;
    int    mon_streak = 0;

    always @(negedge clk) begin
        txn_t e;
        if (sb_on && nrst) begin
            check("wait_exclusive", 32'(bus.iwait | bus.dwait), 32'd1);
            if (!bus.iREN) mon_streak = 0;
            if (!bus.dwait) begin
                if (dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dcache_unexpected: got dwait=0, expected no completion (t=%0t)", $time);
                end else begin
                    e = dq.pop_front();
                    check("d_addr", bus.ramaddr, e.addr);
                    if (e.is_wr) begin
                        check("d_wen", 32'(bus.ramWEN), 32'd1);
                        check("d_store", bus.ramstore, e.data);
                    end else begin
                        check("dload", bus.dload, e.data);
                    end
                    check("ramerr_d", 32'(bus.ramerr), 32'(exp_err));
                    if (bus.iREN) begin
                        mon_streak++;
                        check("starve_bound", 32'(mon_streak <= LIMIT), 32'd1);
                    end
                end
            end
            if (!bus.iwait) begin
                mon_streak = 0;
                if (iq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL icache_unexpected: got iwait=0, expected no completion (t=%0t)", $time);
                end else begin
                    e = iq.pop_front();
                    check("i_addr", bus.ramaddr, e.addr);
                    check("i_ren", 32'(bus.ramREN), 32'd1);
                    check("iload", bus.iload, e.data);
                    check("ramerr_i", 32'(bus.ramerr), 32'(exp_err));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic collect(input int n, output string seq);
        seq = "";
        for (int c = 0; c < 200 && seq.len() < n; c++) begin
            @(negedge clk);
            if (!bus.dwait) seq = {seq, "D"};
            if (!bus.iwait) seq = {seq, "I"};
        end
    endtask

    initial begin
        string     seq;
        string     exp_seq;
        ramstate_t wr_st  [5];
        logic      wr_dw  [5];
        txn_t      t;

        nrst      = 1'b0;
        bus.iREN  = 1'b0;
        bus.iaddr = '0;
        bus.dREN  = 1'b0;
        bus.dWEN  = 1'b0;
        bus.daddr = '0;
        bus.dstore = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_iwait",   32'(bus.iwait),  32'd1);
        check("rst_dwait",   32'(bus.dwait),  32'd1);
        check("rst_ramREN",  32'(bus.ramREN), 32'd0);
        check("rst_ramWEN",  32'(bus.ramWEN), 32'd0);
        check("rst_ramaddr", bus.ramaddr,     32'd0);
        check("rst_ramerr",  32'(bus.ramerr), 32'd0);
        nrst = 1'b1;

        // Write with two BUSY cycles: dwait falls only in the 4th cycle.
        wr_st = '{FREE, BUSY, BUSY, ACCESS, FREE};
        wr_dw = '{1'b1, 1'b1, 1'b1, 1'b0,   1'b1};
        tick();
        bus.dWEN   = 1'b1;
        bus.daddr  = 32'h100;
        bus.dstore = 32'hDEADBEEF;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            man_state = wr_st[c];
            if (c == 4) bus.dWEN = 1'b0;
            @(negedge clk);
            check($sformatf("wr_dwait_c%0d", c + 1), 32'(bus.dwait), 32'(wr_dw[c]));
            check($sformatf("wr_iwait_c%0d", c + 1), 32'(bus.iwait), 32'd1);
            if (c == 1 || c == 3) begin
                check("wr_ramWEN",   32'(bus.ramWEN), 32'd1);
                check("wr_ramREN",   32'(bus.ramREN), 32'd0);
                check("wr_ramaddr",  bus.ramaddr,     32'h100);
                check("wr_ramstore", bus.ramstore,    32'hDEADBEEF);
            end
        end
        check("wr_idle_ramWEN", 32'(bus.ramWEN), 32'd0);

        // Both caches requesting: four dcache completions, then icache, then dcache again.
        ram_auto = 1'b1;
        lat_min  = 1;
        lat_max  = 1;
        tick();
        bus.dREN  = 1'b1;
        bus.daddr = 32'h2000;
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h80;
        collect(6, seq);
        exp_seq = "DDDDID";
        for (int i = 0; i < 6; i++) check($sformatf("starve_order_%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
        tick();
        bus.dREN = 1'b0;
        bus.iREN = 1'b0;

        // icache read: the data arrives in the ACCESS cycle.
        ram_auto = 1'b0;
        tick();
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h40;
        man_load  = 32'h12345678;
        man_state = FREE;
        @(negedge clk);
        check("rd_idle_iwait", 32'(bus.iwait), 32'd1);
        tick();
        man_state = ACCESS;
        @(negedge clk);
        check("rd_iwait",   32'(bus.iwait), 32'd0);
        check("rd_dwait",   32'(bus.dwait), 32'd1);
        check("rd_iload",   bus.iload,      32'h12345678);
        check("rd_ramREN",  32'(bus.ramREN), 32'd1);
        check("rd_ramaddr", bus.ramaddr,    32'h40);
        tick();
        bus.iREN  = 1'b0;
        man_state = FREE;
        @(negedge clk);
        check("rd_after_iwait", 32'(bus.iwait), 32'd1);

        // ERROR for one cycle, then ACCESS: the transfer is retried and ramerr stays set.
        tick();
        bus.dREN  = 1'b1;
        bus.daddr = 32'h200;
        tick();
        man_state = ERROR;
        @(negedge clk);
        check("err_dwait",  32'(bus.dwait),  32'd1);
        check("err_ramREN", 32'(bus.ramREN), 32'd1);
        tick();
        man_state = ACCESS;
        @(negedge clk);
        check("err_ramerr_set", 32'(bus.ramerr), 32'd1);
        check("err_complete",   32'(bus.dwait),  32'd0);
        tick();
        bus.dREN  = 1'b0;
        man_state = FREE;
        repeat (2) tick();
        @(negedge clk);
        check("err_ramerr_sticky", 32'(bus.ramerr), 32'd1);

        // dcache drops its request while the RAM is BUSY: no completion pulse, then back to IDLE.
        tick();
        bus.dREN  = 1'b1;
        bus.daddr = 32'h300;
        tick();
        man_state = BUSY;
        @(negedge clk);
        check("abort_ramREN", 32'(bus.ramREN), 32'd1);
        tick();
        bus.dREN = 1'b0;
        @(negedge clk);
        check("abort_dwait", 32'(bus.dwait), 32'd1);
        tick();
        man_state = FREE;
        @(negedge clk);
        check("abort_idle_addr",  bus.ramaddr,    32'd0);
        check("abort_idle_dwait", 32'(bus.dwait), 32'd1);

        // Reset in the middle of an icache grant after two dcache completions.
        ram_auto = 1'b1;
        tick();
        bus.dREN  = 1'b1;
        bus.daddr = 32'h2004;
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h44;
        collect(2, seq);
        exp_seq = "DD";
        for (int i = 0; i < 2; i++) check($sformatf("pre_rst_order_%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
        tick();
        bus.dREN = 1'b0;
        tick();
        @(negedge clk);
        check("pre_rst_ramREN",  32'(bus.ramREN), 32'd1);
        check("pre_rst_ramaddr", bus.ramaddr,     32'h44);
        check("pre_rst_dstreak", 32'(dut.dstreak_q), 32'd2);
        #2;
        nrst = 1'b0;
        #1;
        check("rst_mid_ramREN",  32'(bus.ramREN),    32'd0);
        check("rst_mid_iwait",   32'(bus.iwait),     32'd1);
        check("rst_mid_dstreak", 32'(dut.dstreak_q), 32'd0);
        check("rst_mid_ramerr",  32'(bus.ramerr),    32'd0);
        tick();
        bus.iREN = 1'b0;
        nrst     = 1'b1;
        repeat (2) tick();

        // Random traffic. icache reads a region that is never written. dcache reads and writes its own region.
        lat_min = 0;
        lat_max = 2;
        err_en  = 1'b1;
        sb_on   = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (dq.size() == 0) begin
                if ($urandom_range(0, 3) != 0) begin
                    t.is_wr = ($urandom_range(0, 1) == 1);
                    t.addr  = 32'h1000 + 32'(4 * $urandom_range(0, 15));
                    if (t.is_wr) begin
                        t.data = $urandom;
                        ref_mem[t.addr] = t.data;
                        bus.dWEN = 1'b1;
                        bus.dREN = ($urandom_range(0, 3) == 0);
                    end else begin
                        t.data = ref_mem.exists(t.addr) ? ref_mem[t.addr] : init_word(t.addr);
                        bus.dWEN = 1'b0;
                        bus.dREN = 1'b1;
                    end
                    bus.daddr  = t.addr;
                    bus.dstore = t.is_wr ? t.data : $urandom;
                    dq.push_back(t);
                end else begin
                    bus.dREN = 1'b0;
                    bus.dWEN = 1'b0;
                end
            end
            if (iq.size() == 0) begin
                if ($urandom_range(0, 2) != 0) begin
                    t.is_wr   = 1'b0;
                    t.addr    = 32'(4 * $urandom_range(0, 15));
                    t.data    = init_word(t.addr);
                    bus.iaddr = t.addr;
                    bus.iREN  = 1'b1;
                    iq.push_back(t);
                end else begin
                    bus.iREN = 1'b0;
                end
            end
        end

        for (int c = 0; c < 200 && (dq.size() + iq.size()) != 0; c++) begin
            tick();
            if (dq.size() == 0) begin
                bus.dREN = 1'b0;
                bus.dWEN = 1'b0;
            end
            if (iq.size() == 0) bus.iREN = 1'b0;
        end
        check("drain_outstanding", 32'(dq.size() + iq.size()), 32'd0);
        tick();
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
        bus.iREN = 1'b0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
